// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and helpers for the mux scan controller.
//   scan_state_e : scan FSM state encoding
//   cnt_width()  : counter width for a modulus n, clog2(n) floored at one bit
package mux_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_STALL  = 3'd3,
    ST_DRAIN  = 3'd4
  } scan_state_e;

  // Width of a counter that runs 0..n-1; a one-bit floor keeps degenerate
  // parameter values (n == 1) from producing zero-width vectors.
  function automatic int cnt_width(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// mux_scan_if: valid/ready word bus between the scan controller and its consumer.
//   word_data  : packed samples, earliest channel in bit 0 (master -> slave)
//   word_valid : word_data holds a word (master -> slave)
//   word_ready : consumer accepts the word (slave -> master)
interface mux_scan_if #(
  parameter int WORD_WIDTH = 8
);

  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/mux_scan_packer.sv
// mux_scan_packer: accumulates sampled bits LSB-first and presents completed
// words on the valid/ready bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : drop the partial word and any pending word
//   capture    : bit_in is a new sample this cycle
//   flush      : this capture ends the word even if not full (upper bits zero)
//   bit_in     : sample value
//   full       : the next capture fills the last bit position
//   word_if    : output word bus (master side)
module mux_scan_packer
  import mux_scan_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      capture,
  input  logic      flush,
  input  logic      bit_in,
  output logic      full,
  mux_scan_if.master word_if
);

  localparam int                BCW      = cnt_width(WORD_WIDTH);
  localparam logic [BCW-1:0]    LAST_IDX = BCW'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] acc_r;
  logic [WORD_WIDTH-1:0] data_r;
  logic [WORD_WIDTH-1:0] bit_word_s;
  logic [BCW-1:0]        bitcnt_r;
  logic                  valid_r;
  logic                  complete_s;

  assign full       = (bitcnt_r == LAST_IDX);
  assign complete_s = capture && (full || flush);

  // Place the incoming sample at its bit position within the word.
  always_comb begin
    bit_word_s = '0;
    if (capture) begin
      bit_word_s[bitcnt_r] = bit_in;
    end else begin
      bit_word_s = '0;
    end
  end

  // Accumulator, bit position and the output word register with its handshake.
  // The controller only completes a word when the previous one is gone or is
  // being accepted on this same edge, so a completing capture may overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      data_r   <= '0;
      bitcnt_r <= '0;
      valid_r  <= 1'b0;
    end else if (clear) begin
      acc_r    <= '0;
      bitcnt_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (valid_r && word_if.word_ready) begin
        valid_r <= 1'b0;
      end
      if (complete_s) begin
        data_r   <= acc_r | bit_word_s;
        valid_r  <= 1'b1;
        acc_r    <= '0;
        bitcnt_r <= '0;
      end else if (capture) begin
        acc_r    <= acc_r | bit_word_s;
        bitcnt_r <= bitcnt_r + BCW'(1);
      end
    end
  end

  assign word_if.word_data  = data_r;
  assign word_if.word_valid = valid_r;

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a mux select across [first_ch..last_ch] (wrapping past
// the top channel), samples the mux output after a settle interval and packs
// the samples into words on a valid/ready bus.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin scan (idle only) / cancel scan from any state
//   continuous          : loop back to first_ch after last_ch (latched at start)
//   first_ch, last_ch   : channel range (latched at start)
//   select              : mux select drive
//   mux_out             : mux output being sampled
//   word_if             : packed word bus (master side)
//   busy, done          : scan in progress / one-cycle end-of-scan pulse
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SELECT_LINES = 8,
  parameter int SETTLE       = 2,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    continuous,
  input  logic [SELECT_LINES-1:0] first_ch,
  input  logic [SELECT_LINES-1:0] last_ch,
  output logic [SELECT_LINES-1:0] select,
  input  logic                    mux_out,
  mux_scan_if.master              word_if,
  output logic                    busy,
  output logic                    done
);

  localparam int SCW = cnt_width(SETTLE);
  // SETTLE state lasts SETTLE-1 cycles and SAMPLE one more, so the exit is
  // taken when the count is about to reach SETTLE-1.
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'((SETTLE >= 2) ? (SETTLE - 2) : 0);
  localparam scan_state_e    SETTLE_ENTRY = (SETTLE > 1) ? ST_SETTLE : ST_SAMPLE;

  scan_state_e             state_r;
  logic [SELECT_LINES-1:0] sel_r;
  logic [SELECT_LINES-1:0] first_r;
  logic [SELECT_LINES-1:0] last_r;
  logic [SCW-1:0]          cnt_r;
  logic                    cont_r;
  logic                    busy_r;
  logic                    done_r;

  logic is_last_s;
  logic pk_full_s;
  logic xfer_s;
  logic stall_s;
  logic capture_s;

  assign is_last_s = (sel_r == last_r);
  assign xfer_s    = word_if.word_valid && word_if.word_ready;
  // A word-completing capture must wait while the previous word is still held.
  assign stall_s   = (state_r == ST_SAMPLE) && (pk_full_s || is_last_s) &&
                     word_if.word_valid && !word_if.word_ready;
  assign capture_s = (state_r == ST_SAMPLE) && !stall_s && !abort;

  // Scan FSM: channel stepping, settle timing, busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sel_r   <= '0;
      first_r <= '0;
      last_r  <= '0;
      cnt_r   <= '0;
      cont_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              first_r <= first_ch;
              last_r  <= last_ch;
              cont_r  <= continuous;
              sel_r   <= first_ch;
              cnt_r   <= '0;
              busy_r  <= 1'b1;
              state_r <= SETTLE_ENTRY;
            end
          end
          ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
              state_r <= ST_SAMPLE;
            end else begin
              cnt_r <= cnt_r + SCW'(1);
            end
          end
          ST_SAMPLE: begin
            if (stall_s) begin
              state_r <= ST_STALL;
            end else if (is_last_s) begin
              if (cont_r) begin
                sel_r   <= first_r;
                cnt_r   <= '0;
                state_r <= SETTLE_ENTRY;
              end else begin
                state_r <= ST_DRAIN;
              end
            end else begin
              sel_r   <= sel_r + SELECT_LINES'(1);
              cnt_r   <= '0;
              state_r <= SETTLE_ENTRY;
            end
          end
          ST_STALL: begin
            if (xfer_s) begin
              state_r <= ST_SAMPLE;
            end
          end
          ST_DRAIN: begin
            if (xfer_s || !word_if.word_valid) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  mux_scan_packer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (abort),
    .capture (capture_s),
    .flush   (is_last_s),
    .bit_in  (mux_out),
    .full    (pk_full_s),
    .word_if (word_if)
  );

  assign select = sel_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule
